// File: rtl/conv_pkg.sv
// Shared types and derived constants for the folded 5x5 convolution scheduler.
package conv_pkg;

  localparam int unsigned IMG_W   = 7;
  localparam int unsigned K       = 5;
  localparam int unsigned NUM_KER = 2;
  localparam int unsigned AW      = 6;

  localparam int unsigned OW   = IMG_W - K + 1;
  localparam int unsigned KK   = K * K;
  localparam int unsigned NWIN = OW * OW * NUM_KER;

  // Counter width that never collapses to zero bits for a count of 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned KER_W = cnt_w(NUM_KER);
  localparam int unsigned POS_W = cnt_w(OW);
  localparam int unsigned TAP_W = cnt_w(K);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, OUT, DONE} state_t;

  typedef struct packed {
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
    logic [KER_W-1:0] ker;
  } win_idx_t;

endpackage

// File: rtl/conv_window_sched_if.sv
// Host, memory-read, MAC-strobe and result-handshake signals of the window scheduler.
interface conv_window_sched_if;
  import conv_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             fmap_cs;
  logic [AW-1:0]    fmap_addr;
  logic [AW-1:0]    w_addr;
  logic             mac_en;
  logic             mac_clr;
  logic             out_valid;
  logic             out_ready;
  logic [KER_W-1:0] out_ker;
  logic [POS_W-1:0] out_row;
  logic [POS_W-1:0] out_col;

  modport master (
    input  start, out_ready,
    output busy, done, fmap_cs, fmap_addr, w_addr, mac_en, mac_clr,
           out_valid, out_ker, out_row, out_col
  );

  modport slave (
    output start, out_ready,
    input  busy, done, fmap_cs, fmap_addr, w_addr, mac_en, mac_clr,
           out_valid, out_ker, out_row, out_col
  );
endinterface

// File: rtl/conv_addr_gen.sv
// Registered index-to-address math for feature-map and weight memories.
module conv_addr_gen
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] row,
  input  logic [POS_W-1:0] col,
  input  logic [KER_W-1:0] ker,
  input  logic [TAP_W-1:0] ky,
  input  logic [TAP_W-1:0] kx,
  output logic [AW-1:0]    fmap_addr,
  output logic [AW-1:0]    w_addr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      fmap_addr <= '0;
      w_addr    <= '0;
    end else begin
      fmap_addr <= AW'((32'(row) + 32'(ky)) * IMG_W + 32'(col) + 32'(kx));
      w_addr    <= AW'(32'(ker) * KK + 32'(ky) * K + 32'(kx));
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// Job-level scheduler: walks row/col/ker/ky/kx, issues one tap per cycle,
// strobes the MAC one cycle behind the reads and hands out each window sum.
module conv_window_sched
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  conv_window_sched_if.master bus
);

  if ((IMG_W * IMG_W - 1) >= (1 << AW) || (NUM_KER * KK - 1) >= (1 << AW)) begin : g_aw_check
    $error("conv_window_sched: AW too small for map or weight store");
  end

  state_t           state, state_n;
  win_idx_t         win, win_n;
  logic [TAP_W-1:0] ky, kx, ky_n, kx_n;
  logic             busy_n, done_n, cs_n, en_n, clr_n, valid_n;
  logic             last_tap, last_win;

  assign last_tap = (ky == TAP_W'(K - 1)) && (kx == TAP_W'(K - 1));
  assign last_win = (win.row == POS_W'(OW - 1)) && (win.col == POS_W'(OW - 1)) &&
                    (win.ker == KER_W'(NUM_KER - 1));

  // Next-state, next-index and next-output logic.
  always_comb begin
    state_n = state;
    win_n   = win;
    ky_n    = ky;
    kx_n    = kx;
    busy_n  = bus.busy;
    done_n  = 1'b0;
    cs_n    = 1'b0;
    en_n    = bus.fmap_cs;
    clr_n   = bus.fmap_cs && (ky == '0) && (kx == '0);
    valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
          busy_n  = 1'b1;
          cs_n    = 1'b1;
          win_n   = '0;
          ky_n    = '0;
          kx_n    = '0;
        end
      end
      RUN: begin
        if (last_tap) begin
          state_n = FLUSH;
        end else begin
          cs_n = 1'b1;
          if (kx == TAP_W'(K - 1)) begin
            kx_n = '0;
            ky_n = ky + TAP_W'(1);
          end else begin
            kx_n = kx + TAP_W'(1);
          end
        end
      end
      FLUSH: begin
        state_n = OUT;
        valid_n = 1'b1;
      end
      OUT: begin
        valid_n = 1'b1;
        if (bus.out_ready) begin
          valid_n = 1'b0;
          ky_n    = '0;
          kx_n    = '0;
          if (last_win) begin
            state_n = DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            win_n   = '0;
          end else begin
            state_n = RUN;
            cs_n    = 1'b1;
            if (win.ker != KER_W'(NUM_KER - 1)) begin
              win_n.ker = win.ker + KER_W'(1);
            end else begin
              win_n.ker = '0;
              if (win.col != POS_W'(OW - 1)) begin
                win_n.col = win.col + POS_W'(1);
              end else begin
                win_n.col = '0;
                win_n.row = win.row + POS_W'(1);
              end
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, indices and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      win           <= '0;
      ky            <= '0;
      kx            <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.fmap_cs   <= 1'b0;
      bus.mac_en    <= 1'b0;
      bus.mac_clr   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_ker   <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
    end else begin
      state         <= state_n;
      win           <= win_n;
      ky            <= ky_n;
      kx            <= kx_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
      bus.fmap_cs   <= cs_n;
      bus.mac_en    <= en_n;
      bus.mac_clr   <= clr_n;
      bus.out_valid <= valid_n;
      bus.out_ker   <= valid_n ? win_n.ker : '0;
      bus.out_row   <= valid_n ? win_n.row : '0;
      bus.out_col   <= valid_n ? win_n.col : '0;
    end
  end

  // Addresses track the indices the registers are about to hold.
  conv_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .row       (win_n.row),
    .col       (win_n.col),
    .ker       (win_n.ker),
    .ky        (ky_n),
    .kx        (kx_n),
    .fmap_addr (bus.fmap_addr),
    .w_addr    (bus.w_addr)
  );

endmodule
